memc_dma_responder: RTL and testbench

//   Memory-controller end of the per-lane DMA-to-memory interface driven by dma_cont.

---
 rtl/memc_dma_responder.sv | 155 +++++++++++++++
 tb/tb_memc_dma_responder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memc_dma_responder.sv
// Lane memory-controller responder: arbitrates DMA writes/reads onto one SRAM port
// and returns read data in order through a credit-protected FIFO.
module memc_dma_responder #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              dma__memc__write_valid,
  input  logic [ADDR_W-1:0] dma__memc__write_address,
  input  logic [DATA_W-1:0] dma__memc__write_data,
  output logic              memc__dma__write_ready,
  input  logic              dma__memc__read_valid,
  input  logic [ADDR_W-1:0] dma__memc__read_address,
  input  logic              dma__memc__read_pause,
  output logic              memc__dma__read_ready,
  output logic [DATA_W-1:0] memc__dma__read_data,
  output logic              memc__dma__read_data_valid,
  output logic              memc__sram__enable,
  output logic              memc__sram__write,
  output logic [ADDR_W-1:0] memc__sram__address,
  output logic [DATA_W-1:0] memc__sram__wdata,
  input  logic [DATA_W-1:0] sram__memc__rdata
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {WR_PRI, RD_PRI} token_t;

  token_t            token, token_nxt;
  logic [CW-1:0]     credits;
  logic [CW-1:0]     count;
  logic [PW-1:0]     wptr, rptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [RD_LAT-1:0] rd_pipe;

  logic rd_ok, rd_req;
  logic wr_grant, rd_grant;
  logic push, pop, fifo_empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rd_ok  = credits != '0;
  assign rd_req = dma__memc__read_valid && rd_ok;

  // Readies are held low while reset is asserted so nothing issues.
  always_comb begin
    memc__dma__write_ready = 1'b0;
    memc__dma__read_ready  = 1'b0;
    if (!reset_poweron) begin
      memc__dma__write_ready = !rd_req || (token == WR_PRI);
      memc__dma__read_ready  = rd_ok &&
        (!dma__memc__write_valid || (token == RD_PRI));
    end
  end

  assign wr_grant = dma__memc__write_valid && memc__dma__write_ready;
  assign rd_grant = dma__memc__read_valid && memc__dma__read_ready;

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) token <= WR_PRI;
    else               token <= token_nxt;
  end

  always_comb begin
    token_nxt = token;
    unique case (1'b1)
      wr_grant && rd_req:                 token_nxt = RD_PRI;
      rd_grant && dma__memc__write_valid: token_nxt = WR_PRI;
      default:                            token_nxt = token;
    endcase
  end

  always_comb begin
    memc__sram__enable  = 1'b0;
    memc__sram__write   = 1'b0;
    memc__sram__address = '0;
    memc__sram__wdata   = '0;
    unique case (1'b1)
      wr_grant: begin
        memc__sram__enable  = 1'b1;
        memc__sram__write   = 1'b1;
        memc__sram__address = dma__memc__write_address;
        memc__sram__wdata   = dma__memc__write_data;
      end
      rd_grant: begin
        memc__sram__enable  = 1'b1;
        memc__sram__address = dma__memc__read_address;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= rd_grant;
      for (int i = 1; i < RD_LAT; i++)
        rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign push       = rd_pipe[RD_LAT-1];
  assign fifo_empty = count == '0;
  assign pop        = memc__dma__read_data_valid;

  assign memc__dma__read_data_valid = !fifo_empty && !dma__memc__read_pause;
  assign memc__dma__read_data =
    memc__dma__read_data_valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= sram__memc__rdata;
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Credits cover reads in the pipe plus entries in the FIFO.
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      credits <= CW'(FIFO_DEPTH);
    end else begin
      unique case ({rd_grant, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  a_one_grant: assert property (@(posedge clk) disable iff (reset_poweron)
    !(wr_grant && rd_grant));
  a_no_overflow: assert property (@(posedge clk) disable iff (reset_poweron)
    !(push && !pop && count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_memc_dma_responder.sv
// Bench for memc_dma_responder: arbitration table, directed corner sequences
// and random traffic checked against a queue-based reference model.
module tb_memc_dma_responder;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wv, rv, pause;
  logic [AW-1:0] wa, ra;
  logic [DW-1:0] wd;
  logic          wr_rdy, rd_rdy, rvalid;
  logic [DW-1:0] rdata;
  logic          en, we;
  logic [AW-1:0] sa;
  logic [DW-1:0] sw, sr;

  always #5 clk = ~clk;

  memc_dma_responder #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .FIFO_DEPTH(DEP)
  ) dut (
    .clk                        (clk),
    .reset_poweron              (rst),
    .dma__memc__write_valid     (wv),
    .dma__memc__write_address   (wa),
    .dma__memc__write_data      (wd),
    .memc__dma__write_ready     (wr_rdy),
    .dma__memc__read_valid      (rv),
    .dma__memc__read_address    (ra),
    .dma__memc__read_pause      (pause),
    .memc__dma__read_ready      (rd_rdy),
    .memc__dma__read_data       (rdata),
    .memc__dma__read_data_valid (rvalid),
    .memc__sram__enable         (en),
    .memc__sram__write          (we),
    .memc__sram__address        (sa),
    .memc__sram__wdata          (sw),
    .sram__memc__rdata          (sr)
  );

  // SRAM macro model with LAT-cycle read latency
  logic [DW-1:0] sram [2**AW];
  logic [DW-1:0] rq [LAT];
  always @(posedge clk) begin
    if (en && we) sram[sa] <= sw;
    rq[0] <= (en && !we) ? sram[sa] : '0;
    for (int i = 1; i < LAT; i++) rq[i] <= rq[i-1];
  end
  assign sr = rq[LAT-1];

  // Reference model: shadow memory, queue of pending reads with ready time
  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } pend_t;
  pend_t         q[$];
  logic [DW-1:0] shadow [2**AW];
  bit            tok_rd;
  int            cyc, total, bad, got, acc;
  bit            last_wg, last_rg, last_ev;
  int            last_cyc;
  logic [DW-1:0] last_data;

  typedef struct packed {
    logic wv, rv, p, ewr, erd, een, ewe;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic step();
    bit rok, rreq, ewr, erd, wg, rg, ev;
    #1;
    rok  = q.size() < DEP;
    rreq = rv && rok;
    ewr  = !rreq || !tok_rd;
    erd  = rok && (!wv || tok_rd);
    wg   = wv && ewr;
    rg   = rv && erd;
    ev   = q.size() != 0 && q[0].t <= cyc && !pause;
    chk("write_ready", 64'(wr_rdy), 64'(ewr));
    chk("read_ready", 64'(rd_rdy), 64'(erd));
    chk("sram_enable", 64'(en), 64'(wg || rg));
    chk("sram_write", 64'(we), 64'(wg));
    chk("sram_address", 64'(sa), 64'(wg ? wa : rg ? ra : AW'(0)));
    chk("sram_wdata", 64'(sw), 64'(wg ? wd : DW'(0)));
    chk("read_data_valid", 64'(rvalid), 64'(ev));
    chk("read_data_known", 64'($isunknown(rdata)), 64'(0));
    last_ev  = ev;
    last_cyc = cyc;
    if (ev) begin
      chk("read_data", 64'(rdata), 64'(q[0].d));
      last_data = q[0].d;
      void'(q.pop_front());
      got++;
    end
    if (wg) shadow[wa] = wd;
    if (rg) begin
      q.push_back('{shadow[ra], cyc + LAT + 1});
      acc++;
    end
    if (wg && rreq)    tok_rd = 1'b1;
    else if (rg && wv) tok_rd = 1'b0;
    last_wg = wg;
    last_rg = rg;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    wv = 0; rv = 0; pause = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int k;
    wv = 1; rv = 0; wa = a; wd = d;
    k = 0;
    do begin step(); k++; end while (!last_wg && k < 20);
    wv = 0;
  endtask

  initial begin
    int n, g0, ta, tv, k;
    logic [DW-1:0] dd [2];
    for (int i = 0; i < 2**AW; i++) begin
      sram[i] = '0;
      shadow[i] = '0;
    end
    for (int i = 0; i < LAT; i++) rq[i] = '0;
    total = 0; bad = 0; got = 0; acc = 0; cyc = 0; tok_rd = 0;
    rst = 1; wv = 0; rv = 0; pause = 0; wa = '0; ra = '0; wd = '0;

    tbl[0]  = '{1, 1, 0, 1, 0, 1, 1};
    tbl[1]  = '{1, 1, 0, 0, 1, 1, 0};
    tbl[2]  = '{1, 1, 0, 1, 0, 1, 1};
    tbl[3]  = '{1, 1, 0, 0, 1, 1, 0};
    tbl[4]  = '{1, 1, 0, 1, 0, 1, 1};
    tbl[5]  = '{1, 1, 0, 0, 1, 1, 0};
    tbl[6]  = '{1, 1, 0, 1, 0, 1, 1};
    tbl[7]  = '{1, 1, 0, 0, 1, 1, 0};
    tbl[8]  = '{0, 1, 0, 1, 1, 1, 0};
    tbl[9]  = '{1, 0, 0, 1, 0, 1, 1};
    tbl[10] = '{0, 0, 0, 1, 1, 0, 0};

    // reset state with requests pending
    repeat (2) @(negedge clk);
    wv = 1; rv = 1;
    #1;
    chk("rst_write_ready", 64'(wr_rdy), 64'(0));
    chk("rst_read_ready", 64'(rd_rdy), 64'(0));
    chk("rst_data_valid", 64'(rvalid), 64'(0));
    chk("rst_sram_enable", 64'(en), 64'(0));
    chk("rst_read_data", 64'(rdata), 64'(0));
    @(negedge clk);
    rst = 0;

    // contention table: strict W,R alternation starting with W
    for (int i = 0; i < 11; i++) begin
      wv = tbl[i].wv; rv = tbl[i].rv; pause = tbl[i].p;
      wa = AW'(12'h080 + i); wd = DW'(32'hA000 + i);
      ra = AW'(12'h080 + i - 1);
      #1;
      chk($sformatf("tbl%0d_write_ready", i), 64'(wr_rdy), 64'(tbl[i].ewr));
      chk($sformatf("tbl%0d_read_ready", i), 64'(rd_rdy), 64'(tbl[i].erd));
      chk($sformatf("tbl%0d_enable", i), 64'(en), 64'(tbl[i].een));
      chk($sformatf("tbl%0d_write", i), 64'(we), 64'(tbl[i].ewe));
      step();
    end
    idle(10);

    // write then read same address, minimum latency
    do_write(AW'(12'h010), 32'hDEADBEEF);
    rv = 1; ra = AW'(12'h010);
    step();
    ta = last_cyc;
    chk("t1_read_accept", 64'(last_rg), 64'(1));
    rv = 0;
    tv = -1;
    for (int i = 0; i < 10 && tv < 0; i++) begin
      step();
      if (last_ev) tv = last_cyc;
    end
    chk("t1_latency", 64'(tv - ta), 64'(LAT + 1));
    chk("t1_data", 64'(last_data), 64'(32'hDEADBEEF));
    idle(3);

    // address bounds
    do_write(AW'(0), 32'h0BAD_F00D);
    do_write(AW'(10'h3FF), 32'hC0DE_CAFE);
    rv = 1; ra = AW'(0);
    step();
    ra = AW'(10'h3FF);
    step();
    rv = 0;
    k = 0;
    for (int i = 0; i < 12 && k < 2; i++) begin
      step();
      if (last_ev) begin dd[k] = last_data; k++; end
    end
    chk("t6_count", 64'(k), 64'(2));
    chk("t6_low", 64'(dd[0]), 64'(32'h0BAD_F00D));
    chk("t6_high", 64'(dd[1]), 64'(32'hC0DE_CAFE));

    // credit limit while paused
    for (int i = 0; i < 10; i++) do_write(AW'(i), DW'(32'h100 + i));
    n = 0; g0 = got;
    rv = 1; pause = 1;
    for (int c = 0; c < 10; c++) begin
      ra = AW'(n);
      step();
      if (last_rg) n++;
    end
    chk("t3_paused_accepts", 64'(n), 64'(DEP));
    pause = 0;
    for (int c = 0; c < 80 && got - g0 < 10; c++) begin
      rv = n < 10; ra = AW'(n);
      step();
      if (last_rg) n++;
    end
    chk("t3_returned", 64'(got - g0), 64'(10));
    idle(3);

    // pause toggling every cycle
    for (int i = 0; i < 16; i++) do_write(AW'(12'h040 + i), $urandom);
    n = 0; g0 = got;
    for (int c = 0; c < 200 && got - g0 < 16; c++) begin
      pause = c[0];
      rv = n < 16; ra = AW'(12'h040 + n);
      step();
      if (last_rg) n++;
    end
    chk("t4_returned", 64'(got - g0), 64'(16));
    idle(3);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      wv = $urandom_range(0, 1) == 1;
      rv = $urandom_range(0, 1) == 1;
      pause = $urandom_range(0, 9) < 3;
      wa = AW'($urandom_range(0, 15));
      ra = AW'($urandom_range(0, 15));
      wd = $urandom;
      step();
    end
    idle(20);
    chk("drain_empty", 64'(q.size()), 64'(0));

    // async reset with three reads in flight
    rv = 1; pause = 1; n = 0;
    for (int c = 0; c < 10 && n < 3; c++) begin
      ra = AW'(c);
      step();
      if (last_rg) n++;
    end
    wv = 1; rv = 1; pause = 0;
    #2;
    rst = 1;
    #1;
    chk("t5_write_ready", 64'(wr_rdy), 64'(0));
    chk("t5_read_ready", 64'(rd_rdy), 64'(0));
    chk("t5_data_valid", 64'(rvalid), 64'(0));
    chk("t5_enable", 64'(en), 64'(0));
    chk("t5_sram_write", 64'(we), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    q.delete();
    tok_rd = 0;
    wv = 0; rv = 0;
    #1;
    chk("t5_ready_after", 64'(rd_rdy), 64'(1));
    idle(8);
    // all four credits must be back
    rv = 1; pause = 1; n = 0;
    for (int c = 0; c < 6; c++) begin
      ra = AW'(c);
      step();
      if (last_rg) n++;
    end
    chk("t5_credits", 64'(n), 64'(DEP));
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
